// File: rtl/jump_target_unit.sv
// Two-stage jump/branch target pipeline: S1 decodes and pre-shifts the operand, S2 forms the target.
// Optional JR misalignment flag is built only when JTU_MISALIGN_CHECK_EN is defined.
module jump_target_unit #(
    parameter int ADDR_W = 32,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       index,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] rs_val,
    output logic              out_valid,
    output logic [ADDR_W-1:0] target,
    output logic              misalign
);

    localparam logic [1:0] MODE_J   = 2'b00;
    localparam logic [1:0] MODE_BR  = 2'b01;
    localparam logic [1:0] MODE_JR  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    localparam logic [ADDR_W-1:0] ONES       = '1;
    localparam logic [ADDR_W-1:0] J_LOW_MASK = ~(ONES << (26 + SHIFT));
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ONES << SHIFT);

    // Handshake: no back-pressure output; a request is taken in any cycle with
    // in_valid=1, stall=0, flush=0 and a non-reserved mode. out_valid marks each
    // result once; while stall=1 the presented result is held, not repeated.
    logic accept;

    logic              s1_valid_d, s1_valid_q;
    logic [1:0]        s1_mode_d,  s1_mode_q;
    logic [ADDR_W-1:0] s1_pc_d,    s1_pc_q;
    logic [ADDR_W-1:0] s1_rs_d,    s1_rs_q;
    logic [ADDR_W-1:0] s1_op_d,    s1_op_q;
    logic              out_valid_d, out_valid_q;
    logic [ADDR_W-1:0] target_d,    target_q;

    always_comb begin
        accept     = in_valid && !stall && !flush && (mode != MODE_RSV);
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_pc_d    = s1_pc_q;
        s1_rs_d    = s1_rs_q;
        s1_op_d    = s1_op_q;
        out_valid_d = out_valid_q;
        target_d    = target_q;

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_mode_d = mode;
                s1_pc_d   = pc_plus4;
                s1_rs_d   = rs_val;
                // One operand register serves both J and BR; JR ignores it.
                if (mode == MODE_J) begin
                    s1_op_d = ADDR_W'(index) << SHIFT;
                end else begin
                    s1_op_d = {{(ADDR_W-16){imm[15]}}, imm} << SHIFT;
                end
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                case (s1_mode_q)
                    MODE_J:  target_d = (s1_pc_q & ~J_LOW_MASK) | s1_op_q;
                    MODE_BR: target_d = s1_pc_q + s1_op_q;
                    MODE_JR: target_d = s1_rs_q;
                    default: target_d = target_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_J;
            s1_pc_q     <= '0;
            s1_rs_q     <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            target_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_pc_q     <= s1_pc_d;
            s1_rs_q     <= s1_rs_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            target_q    <= target_d;
        end
    end

    assign out_valid = out_valid_q;
    assign target    = target_q;

`ifdef JTU_MISALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (!flush && !stall && s1_valid_q) begin
            misalign_d = (s1_mode_q == MODE_JR) && ((s1_rs_q & ALIGN_MASK) != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule
